// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the unified-memory port arbiter.
//   - FSM state encoding (ST_IDLE, ST_ACCESS)
//   - requester port IDs (PORT_IF = 0, PORT_DM = 1)
//   - default address/data widths and the latency ceiling MEM_LAT_MAX
//   - rr_pick: round-robin winner selection between the two ports
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned MEM_LAT_MAX = 7;
  localparam int unsigned LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_t;

  // A lone requester always wins; on a tie the port that did not win last goes.
  function automatic port_t rr_pick(input logic want_if, input logic want_dm,
                                    input port_t last);
    port_t pick;
    if (want_if && want_dm) begin
      pick = (last == PORT_DM) ? PORT_IF : PORT_DM;
    end else if (want_dm) begin
      pick = PORT_DM;
    end else begin
      pick = PORT_IF;
    end
    return pick;
  endfunction

endpackage

// File: rtl/lat_counter.sv
// lat_counter: loadable down-counter that times one fixed-latency memory access.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset (count cleared to 0)
//   load     - load load_val into the counter
//   load_val - start value (the access latency)
//   dec      - decrement enable (while an access is outstanding)
//   done     - high in the cycle whose closing edge takes the count to 0
module lat_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned W = LAT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = dec && (cnt == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the
// instruction-fetch port (IF) and the load/store port (DM). Round-robin
// arbitration, one fixed-latency access outstanding at a time.
// Ports:
//   clk, rst                 - clock; synchronous active-low reset
//   if_req/if_addr           - fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata- fetch accept pulse, data-valid pulse, fetched word
//   dm_req/dm_we/dm_addr/dm_wdata - load/store request (held until dm_gnt)
//   dm_gnt/dm_rvalid/dm_rdata- accept pulse, load-data/store-done pulse, loaded word
//   mem_en/mem_we/mem_addr/mem_wdata - memory strobe (one cycle), write enable, address, data
//   mem_rdata                - memory read data, valid MEM_LAT cycles after mem_en
//   busy                     - high while an access is outstanding
// Optional build macro ARB_STATS_EN adds if_gnt_cnt/dm_gnt_cnt, saturating
// 16-bit grant counters per port.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       if_gnt_cnt,
  output logic [15:0]       dm_gnt_cnt
`endif
);

  state_t state, state_d;
  port_t  last_winner;
  port_t  cur_port;
  port_t  win;
  logic   cur_we;
  logic   eff_if, eff_dm;
  logic   issue;
  logic   complete;
  logic   cnt_done;

  // A request in the same cycle as its own grant is the tail of the request
  // just accepted, not a new one.
  assign eff_if = if_req && !if_gnt;
  assign eff_dm = dm_req && !dm_gnt;
  assign win    = rr_pick(eff_if, eff_dm, last_winner);

  lat_counter #(
    .W(LAT_CNT_W)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (issue),
    .load_val (LAT_CNT_W'(MEM_LAT)),
    .dec      (state == ST_ACCESS),
    .done     (cnt_done)
  );

  assign complete = cnt_done;
  assign busy     = (state == ST_ACCESS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    issue   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (eff_if || eff_dm) begin
          issue   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_winner <= PORT_DM;
      cur_port    <= PORT_IF;
      cur_we      <= 1'b0;
      if_gnt      <= 1'b0;
      dm_gnt      <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rvalid   <= 1'b0;
      dm_rvalid   <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
    end else begin
      if_gnt    <= issue && (win == PORT_IF);
      dm_gnt    <= issue && (win == PORT_DM);
      mem_en    <= issue;
      mem_we    <= issue && (win == PORT_DM) && dm_we;
      if_rvalid <= complete && (cur_port == PORT_IF);
      dm_rvalid <= complete && (cur_port == PORT_DM);

      if (issue) begin
        last_winner <= win;
        cur_port    <= win;
        cur_we      <= (win == PORT_DM) && dm_we;
        if (win == PORT_DM) begin
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else begin
          mem_addr  <= if_addr;
        end
      end

      if (complete && (cur_port == PORT_IF)) begin
        if_rdata <= mem_rdata;
      end
      if (complete && (cur_port == PORT_DM) && !cur_we) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_gnt_cnt <= '0;
      dm_gnt_cnt <= '0;
    end else begin
      if (issue && (win == PORT_IF) && (if_gnt_cnt != '1)) begin
        if_gnt_cnt <= if_gnt_cnt + 1'b1;
      end
      if (issue && (win == PORT_DM) && (dm_gnt_cnt != '1)) begin
        dm_gnt_cnt <= dm_gnt_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the processor's single-port unified memory between the instruction-fetch unit (IF port) and the load/store unit (DM port). Arbitrates round-robin, drives the memory for a fixed-latency access and returns read data or a write acknowledgement to the winning requester. Sits between the processor core's fetch/LS stages and the memory; one access is outstanding at a time.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en high to mem_rdata valid; legal range 1..7

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset; reset while rst==0 at a rising edge of clk
if_req  in  1  fetch request; held high until if_gnt is seen
if_addr  in  ADDR_W  fetch address, stable while if_req high
if_gnt  out  1  one-cycle pulse: fetch accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched word
dm_req  in  1  load/store request; held until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  one-cycle pulse: data access accepted
dm_rvalid  out  1  one-cycle pulse: load data valid or store done
dm_rdata  out  DATA_W  loaded word
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high while an access is outstanding

Behaviour:
- Reset (rst==0 at edge): state IDLE; all outputs 0, including rdata buses; last_winner=DM, so IF wins the first tie; latency counter 0. A mid-access reset abandons the access, produces no rvalid, and ignores late mem_rdata.
- FSM states: IDLE, ACCESS.
- IDLE: the edge that samples any effective req issues the access. At that edge, state goes to ACCESS. The winner's gnt=1, mem_en=1, mem_we = dm_we when DM wins, else 0. The winner's addr/wdata are registered onto mem_*. busy=1 and the counter loads MEM_LAT.
- Arbitration: a single requester wins. Both requesting: the winner is the port other than last_winner, and last_winner is then updated.
- Effective req = req AND NOT own gnt. A req seen in the same cycle its gnt is high is ignored, which prevents double issue.
- gnt and mem_en last exactly one cycle. mem_* addr/wdata hold their value until the next issue.
- ACCESS: the counter decrements each edge. At the edge where the counter reaches 0 (the MEM_LAT-th edge after issue):
  - Load/fetch: rdata = mem_rdata and the winner's rvalid=1 for one cycle.
  - Store: dm_rvalid=1 and dm_rdata unchanged.
  - State returns to IDLE and busy=0.
- Throughput: issue-to-rvalid = MEM_LAT edges. With req continuously high the next issue happens in the cycle after rvalid (MEM_LAT+1 cycles per access). Requests arriving during ACCESS wait.
- rdata registers of a port hold their last value until that port's next completion.

Optional Feature:
ARB_STATS_EN: when defined, adds outputs if_gnt_cnt and dm_gnt_cnt (16 bits each). Each counts its port's gnt pulses, saturates at 16'hFFFF and clears on reset. When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (ST_IDLE, ST_ACCESS)
  - port IDs (PORT_IF=0, PORT_DM=1)
  - default ADDR_W/DATA_W
  - MEM_LAT_MAX=7
- One natural sub-module: lat_counter, a loadable down-counter with a done pulse, width $clog2(MEM_LAT_MAX+1).

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then 1, no req. All outputs 0 and no mem_en for 10 cycles.
- Single fetch: if_req, if_addr=10'h004, memory returns 32'h1234_5678. if_gnt pulses 1 cycle after req. if_rvalid with if_rdata=32'h1234_5678 arrives 2 edges after mem_en (MEM_LAT=2).
- Store then load: dm store addr 10'h020 data 32'hDEAD_BEEF gives mem_we=1 and dm_rvalid 2 edges later. Load from 10'h020 then returns dm_rdata=32'hDEAD_BEEF.
- Contention: if_req and dm_req raised in the same cycle after reset. IF is granted first and DM next. With both held for 4 accesses, grants alternate IF, DM, IF, DM. Each access takes 3 cycles and there is never more than one mem_en outstanding.
- Reset mid-access: drive rst=0 at the edge after mem_en. No rvalid occurs, busy=0, and a new if_req afterwards gets if_gnt normally.
- ARB_STATS_EN: after 3 IF and 2 DM grants, if_gnt_cnt=3 and dm_gnt_cnt=2. Forcing 65540 IF grants holds if_gnt_cnt at 16'hFFFF.
